// File: rtl/gf180mcu_fd_sc_mcu7t5v0__xnor2_sched.sv
// Round-robin scheduler sharing one 1-bit XNOR compare stage among N requesters.
// It walks the granted A/B operand pair LSB first and counts the matching bit positions.
module gf180mcu_fd_sc_mcu7t5v0__xnor2_sched #(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [N-1:0]           REQ,
    input  logic [N*W-1:0]         A,
    input  logic [N*W-1:0]         B,
    input  logic                   ACK,
    output logic [N-1:0]           GNT,
    output logic                   BUSY,
    output logic                   VLD,
    output logic                   EQ,
    output logic [$clog2(W+1)-1:0] MCNT,
    output logic [$clog2(N)-1:0]   ID,
    inout  wire                    VDD,
    inout  wire                    VSS
);

    localparam int MW  = $clog2(W + 1);
    localparam int IDW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_id;
    logic [IDW-1:0] w_grant_idx;
    logic [IDW-1:0] w_probe;
    logic           w_grant_vld;
    logic [W-1:0]   r_a_sh;
    logic [W-1:0]   r_b_sh;
    logic [W-1:0]   w_sel_a;
    logic [W-1:0]   w_sel_b;
    logic [MW-1:0]  r_mcnt;
    logic [MW-1:0]  r_cnt;
    logic           w_bit_match;

    // The supply pins have no logical function.
    wire w_unused_supply = VDD ^ VSS;

    // The search starts at r_ptr, and the IDW-bit index wraps N-1 -> 0 by itself.
    // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_probe     = '0;
        for (int k = 0; k < N; k++) begin
            w_probe = r_ptr + IDW'(k);
            if (!w_grant_vld && REQ[w_probe]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_probe;
            end
        end
    end

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant_idx == IDW'(i)) begin
                w_sel_a = A[i*W +: W];
                w_sel_b = B[i*W +: W];
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        GNT          = '0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_vld) begin
                    GNT[w_grant_idx] = 1'b1;
                    w_next_state     = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt == MW'(1)) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (ACK) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    assign w_bit_match = ~(r_a_sh[0] ^ r_b_sh[0]);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ptr  <= '0;
            r_id   <= '0;
            r_mcnt <= '0;
            r_cnt  <= '0;
            r_a_sh <= '0;
            r_b_sh <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_vld) begin
                        r_a_sh <= w_sel_a;
                        r_b_sh <= w_sel_b;
                        r_id   <= w_grant_idx;
                        r_mcnt <= '0;
                        r_cnt  <= MW'(W);
                    end
                end
                S_SHIFT: begin
                    r_mcnt <= r_mcnt + MW'(w_bit_match);
                    r_a_sh <= r_a_sh >> 1;
                    r_b_sh <= r_b_sh >> 1;
                    r_cnt  <= r_cnt - MW'(1);
                end
                S_DONE: begin
                    if (ACK) begin
                        r_ptr <= r_id + IDW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign BUSY = (r_state != S_IDLE);
    assign VLD  = (r_state == S_DONE);
    assign EQ   = VLD && (r_mcnt == MW'(W));
    assign MCNT = r_mcnt;
    assign ID   = r_id;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__xnor2_sched.sv
// Directed bench for the XNOR compare scheduler: latency, counts, fairness, hold, abort.
module tb_gf180mcu_fd_sc_mcu7t5v0__xnor2_sched;

    localparam int W = 8;
    localparam int N = 4;

    logic           CLK = 1'b0;
    logic           RST;
    logic           ACK;
    logic [N-1:0]   REQ;
    logic [N*W-1:0] A;
    logic [N*W-1:0] B;
    wire  [N-1:0]   GNT;
    wire            BUSY;
    wire            VLD;
    wire            EQ;
    wire  [3:0]     MCNT;
    wire  [1:0]     ID;
    wire            VDD;
    wire            VSS;

    assign VDD = 1'b1;
    assign VSS = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    gf180mcu_fd_sc_mcu7t5v0__xnor2_sched #(.W(W), .N(N)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .REQ  (REQ),
        .A    (A),
        .B    (B),
        .ACK  (ACK),
        .GNT  (GNT),
        .BUSY (BUSY),
        .VLD  (VLD),
        .EQ   (EQ),
        .MCNT (MCNT),
        .ID   (ID),
        .VDD  (VDD),
        .VSS  (VSS)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Entered at a negedge in IDLE with REQ/A/B already driven. It pulses ACK during
    // SHIFT and scrambles A/B mid-compare, both of which must be ignored. It then holds
    // VLD for 'hold' cycles and returns one negedge after the ACK cycle.
    task automatic do_op(input logic [N-1:0] exp_gnt, input logic [1:0] exp_id,
                         input logic [3:0] exp_mcnt, input logic exp_eq,
                         input logic [N-1:0] req_after, input int hold);
        logic [N*W-1:0] a_save;
        logic [N*W-1:0] b_save;
        int lat;
        #1;
        check("gnt", GNT, exp_gnt);
        a_save = A;
        b_save = B;
        lat    = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge CLK);
            if (i == 1) begin
                check("gnt_shift", GNT, 0);
                check("busy_shift", BUSY, 1);
                REQ = req_after;
                A   = ~A;
                B   = B ^ 32'h5A5A_C33C;
            end
            if (i == 3) ACK = 1'b1;
            if (i == 4) ACK = 1'b0;
            if (VLD === 1'b1) begin
                lat = i;
                break;
            end
        end
        A = a_save;
        B = b_save;
        check("latency", lat, W + 1);
        check("mcnt", MCNT, exp_mcnt);
        check("eq", EQ, exp_eq);
        check("id", ID, exp_id);
        for (int h = 0; h < hold; h++) begin
            @(negedge CLK);
            check("vld_hold", VLD, 1);
            check("gnt_hold", GNT, 0);
            check("busy_hold", BUSY, 1);
            check("mcnt_hold", MCNT, exp_mcnt);
            check("eq_hold", EQ, exp_eq);
            check("id_hold", ID, exp_id);
        end
        ACK = 1'b1;
        @(negedge CLK);
        ACK = 1'b0;
        check("vld_after_ack", VLD, 0);
        check("busy_after_ack", BUSY, 0);
    endtask

    initial begin
        logic seen_vld;
        RST = 1'b1;
        ACK = 1'b0;
        REQ = '0;
        A   = '0;
        B   = '0;
        repeat (2) @(negedge CLK);
        check("rst_gnt", GNT, 0);
        check("rst_busy", BUSY, 0);
        check("rst_vld", VLD, 0);
        check("rst_eq", EQ, 0);
        check("rst_mcnt", MCNT, 0);
        check("rst_id", ID, 0);
        RST = 1'b0;
        @(negedge CLK);
        check("idle_noreq_gnt", GNT, 0);
        check("idle_noreq_busy", BUSY, 0);

        // Equal operands: all 8 positions match.
        A[7:0] = 8'hA5; B[7:0] = 8'hA5; REQ = 4'b0001;
        do_op(4'b0001, 2'd0, 4'd8, 1'b1, 4'b0000, 0);

        // Complementary operands: no position matches.
        A[23:16] = 8'hF0; B[23:16] = 8'h0F; REQ = 4'b0100;
        do_op(4'b0100, 2'd2, 4'd0, 1'b0, 4'b0000, 0);

        // A single differing bit gives 7 matches.
        A[23:16] = 8'h01; B[23:16] = 8'h00; REQ = 4'b0100;
        do_op(4'b0100, 2'd2, 4'd7, 1'b0, 4'b0000, 0);

        // ACK in IDLE is ignored.
        ACK = 1'b1;
        @(negedge CLK);
        ACK = 1'b0;
        check("idle_ack_busy", BUSY, 0);
        check("idle_ack_vld", VLD, 0);

        // Round robin from reset with all four requesting continuously.
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        A   = 32'h1234_5678;
        B   = 32'h1234_5679;
        REQ = 4'b1111;
        do_op(4'b0001, 2'd0, 4'd7, 1'b0, 4'b1111, 1);
        do_op(4'b0010, 2'd1, 4'd8, 1'b1, 4'b1111, 1);
        do_op(4'b0100, 2'd2, 4'd8, 1'b1, 4'b1111, 1);
        do_op(4'b1000, 2'd3, 4'd8, 1'b1, 4'b1111, 1);
        do_op(4'b0001, 2'd0, 4'd7, 1'b0, 4'b0000, 1);

        // Result held for 5 cycles while requester 1 waits; it is granted right after ACK.
        A[7:0] = 8'hC3; B[7:0] = 8'h3C; REQ = 4'b0001;
        do_op(4'b0001, 2'd0, 4'd0, 1'b0, 4'b0010, 5);
        A[15:8] = 8'h0F; B[15:8] = 8'h0E;
        do_op(4'b0010, 2'd1, 4'd7, 1'b0, 4'b0000, 0);

        // Abort in the 4th SHIFT cycle. The pointer (2 here) must return to 0.
        A[23:16] = 8'hAA; B[23:16] = 8'hAA; REQ = 4'b0100;
        #1;
        check("abort_gnt", GNT, 4'b0100);
        for (int i = 1; i <= 4; i++) begin
            @(negedge CLK);
            if (i == 1) REQ = 4'b0000;
            if (i == 4) RST = 1'b1;
        end
        @(negedge CLK);
        RST = 1'b0;
        check("abort_gnt0", GNT, 0);
        check("abort_busy", BUSY, 0);
        check("abort_vld", VLD, 0);
        check("abort_eq", EQ, 0);
        check("abort_mcnt", MCNT, 0);
        check("abort_id", ID, 0);
        seen_vld = 1'b0;
        repeat (12) begin
            @(negedge CLK);
            if (VLD !== 1'b0) seen_vld = 1'b1;
        end
        check("abort_no_vld", seen_vld, 0);
        REQ = 4'b1010;
        do_op(4'b0010, 2'd1, 4'd7, 1'b0, 4'b0000, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
